// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed seven-segment display driver.
//
// Scans up to eight common-anode digits one slot at a time. The digit values,
// the enable mask and the decimal points are captured once per frame, so a
// frame never shows a mix of old and new values. Each slot opens with a
// blanking window during which all anodes are off, which suppresses ghosting
// while the segment lines settle.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   data       hex nibble per digit, digit i = data[4i+3:4i]
//   digit_en   1 = digit i lit, 0 = digit i kept dark
//   dp         1 = decimal point of digit i on
//   an         anode selects, active-low, at most one bit low
//   seg        segments a..g on seg[0]..seg[6], active-low
//   dp_n       decimal point, active-low
//   frame_done one-cycle pulse after the edge that captures a new frame
module seg_scan #(
  parameter int DIGITS    = 8,
  parameter int SCAN_CNT  = 100000,
  parameter int BLANK_CNT = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam logic [19:0] LAST_CNT  = 20'(SCAN_CNT - 1);
  localparam logic [19:0] BLANK_LEN = 20'(BLANK_CNT);
  localparam logic [2:0]  LAST_IDX  = 3'(DIGITS - 1);

  // Scan position: slot counter and digit index.
  logic [19:0]         r_cnt;
  logic [2:0]          r_idx;

  // Per-frame snapshot of the inputs.
  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_en;
  logic [DIGITS-1:0]   r_dp;

  logic                w_slotEnd;
  logic                w_frameEnd;
  logic [3:0]          w_nibble;
  logic                w_digEn;
  logic                w_dpSel;
  logic [DIGITS-1:0]   w_anLit;
  logic [6:0]          w_segPat;
  logic                w_blank;

  assign w_slotEnd  = (r_cnt == LAST_CNT);
  assign w_frameEnd = w_slotEnd && (r_idx == LAST_IDX);

  // Select the snapshot fields of the current digit. A compare loop is used
  // instead of a variable part-select so the index width never matters.
  always_comb begin
    w_nibble = 4'h0;
    w_digEn  = 1'b0;
    w_dpSel  = 1'b0;
    w_anLit  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_nibble   = r_data[4*i +: 4];
        w_digEn    = r_en[i];
        w_dpSel    = r_dp[i];
        w_anLit[i] = 1'b0;
      end
    end
  end

  // Hex to active-low segment pattern (g..a).
  always_comb begin
    w_segPat = 7'h7F;
    case (w_nibble)
      4'h0: w_segPat = 7'h40;
      4'h1: w_segPat = 7'h79;
      4'h2: w_segPat = 7'h24;
      4'h3: w_segPat = 7'h30;
      4'h4: w_segPat = 7'h19;
      4'h5: w_segPat = 7'h12;
      4'h6: w_segPat = 7'h02;
      4'h7: w_segPat = 7'h78;
      4'h8: w_segPat = 7'h00;
      4'h9: w_segPat = 7'h10;
      4'hA: w_segPat = 7'h08;
      4'hB: w_segPat = 7'h03;
      4'hC: w_segPat = 7'h46;
      4'hD: w_segPat = 7'h21;
      4'hE: w_segPat = 7'h06;
      4'hF: w_segPat = 7'h0E;
      default: w_segPat = 7'h7F;
    endcase
  end

  assign w_blank = (r_cnt < BLANK_LEN) || !w_digEn;

  // Outputs are registered from the current position, so they trail the
  // position counter by one cycle. The snapshot loads on the last cycle of a
  // frame; that cycle still decodes from the old snapshot because the new
  // values only become visible once the frame has wrapped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= data;
      r_en       <= digit_en;
      r_dp       <= dp;
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (w_blank) begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end else begin
        an   <= w_anLit;
        seg  <= w_segPat;
        dp_n <= ~w_dpSel;
      end

      if (w_slotEnd) begin
        r_cnt <= '0;
        r_idx <= w_frameEnd ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end

      if (w_frameEnd) begin
        r_data <= data;
        r_en   <= digit_en;
        r_dp   <= dp;
      end

      frame_done <= w_frameEnd;
    end
  end

endmodule
